butterfly_stimulus_host: RTL

// - Drives the butterfly's operand port: presents W, B, A on dataIn and strobes ReadyIn.
// - Walks the butterfly's fixed 14-step press sequence and captures the four displayed results (ReY, ImY, ReZ, ImZ) from result.
// - Replaces the manual switch/button front end in simulation and self-test builds.

---
 rtl/butterfly_pkg.sv | 42 ++++
 rtl/butterfly_stimulus_host_step_timer.sv | 31 +++
 rtl/butterfly_stimulus_host.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared types and step ROM for the butterfly stimulus host
package butterfly_pkg;

    // Button-press meaning of each step in the butterfly's operating sequence.
    typedef enum logic [3:0] {
        LD_W,
        LD_B,
        CALC,
        LD_A,
        DISP_REY,
        DISP_IMY,
        DISP_REZ,
        DISP_IMZ,
        CLEAR
    } step_e;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RELEASE,
        DONE
    } host_state_e;

    localparam int N_STEPS = 14;

    localparam step_e STEP_ROM [N_STEPS] = '{
        LD_W, LD_B, CALC, CALC, CALC,
        LD_A, CALC, CALC, CALC,
        DISP_REY, DISP_IMY, DISP_REZ, DISP_IMZ,
        CLEAR
    };

    // Out-of-range indices decode as CLEAR, which drives nothing and captures nothing.
    function automatic step_e step_at(input logic [3:0] idx);
        return (int'(idx) < N_STEPS) ? STEP_ROM[idx] : CLEAR;
    endfunction

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/butterfly_stimulus_host_step_timer.sv
// rtl/butterfly_stimulus_host_step_timer.sv - loadable down-counter with zero flag
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : reload count with load_val (wins over decrement)
//   load_val    : reload value (phase length minus one)
//   count       : current count, decrements towards 0 and stops there
//   zero        : count == 0, i.e. last cycle of the current phase
module step_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic [W-1:0] count,
    output logic         zero
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/butterfly_stimulus_host.sv
// rtl/butterfly_stimulus_host.sv - walks the butterfly press sequence and captures its results
// Ports:
//   Clock, nReset          : clock, asynchronous active-low reset
//   start                  : run request, honoured only in IDLE
//   w_in, b_in, a_in       : operands, latched when start is accepted
//   dataIn, ReadyIn        : operand bus and registered step strobe to the butterfly
//   result                 : butterfly result bus
//   re_y, im_y, re_z, im_z : captured display results
//   busy, done             : sequence in progress / one-cycle completion pulse
module butterfly_stimulus_host
    import butterfly_pkg::*;
#(
    parameter int DATA_W        = 8,
    parameter int HOLD_CYCLES   = 1024,
    parameter int GAP_CYCLES    = 1024,
    parameter int SETTLE_CYCLES = 4
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              start,
    input  logic [DATA_W-1:0] w_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic [DATA_W-1:0] a_in,
    output logic [DATA_W-1:0] dataIn,
    output logic              ReadyIn,
    input  logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] re_y,
    output logic [DATA_W-1:0] im_y,
    output logic [DATA_W-1:0] re_z,
    output logic [DATA_W-1:0] im_z,
    output logic              busy,
    output logic              done
);

    localparam int CNT_W = $clog2(max2(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);
    // Timer counts down through RELEASE, so "SETTLE_CYCLES elapsed" is this remaining value.
    localparam logic [CNT_W-1:0] CAPT_AT   = CNT_W'(GAP_CYCLES - 1 - SETTLE_CYCLES);

    host_state_e       state_q, state_d;
    logic [3:0]        step_q, step_d;
    logic [DATA_W-1:0] w_q, b_q, a_q;
    logic              latch;
    logic              t_load;
    logic [CNT_W-1:0]  t_val;
    logic [CNT_W-1:0]  t_count;
    logic              t_zero;
    logic              ready_d, busy_d, done_d;
    logic [DATA_W-1:0] data_d;
    logic              capture_en;

    step_timer #(.W(CNT_W)) u_timer (
        .clk      (Clock),
        .rst_n    (nReset),
        .load     (t_load),
        .load_val (t_val),
        .count    (t_count),
        .zero     (t_zero)
    );

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        latch   = 1'b0;
        t_load  = 1'b0;
        t_val   = HOLD_LOAD;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                    step_d  = 4'd0;
                    latch   = 1'b1;
                    t_load  = 1'b1;
                    t_val   = HOLD_LOAD;
                end
            end
            DRIVE: begin
                if (t_zero) begin
                    state_d = RELEASE;
                    t_load  = 1'b1;
                    t_val   = GAP_LOAD;
                end
            end
            RELEASE: begin
                if (t_zero) begin
                    if (step_q == 4'(N_STEPS - 1)) begin
                        state_d = DONE;
                    end else begin
                        state_d = DRIVE;
                        step_d  = step_q + 4'd1;
                        t_load  = 1'b1;
                        t_val   = HOLD_LOAD;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state and registered, so every
        // output pin comes straight from a flop.
        ready_d = (state_d == DRIVE);
        busy_d  = (state_d == DRIVE) || (state_d == RELEASE);
        done_d  = (state_d == DONE);
        data_d  = '0;
        if (busy_d) begin
            // On the accepting cycle the operand latches are not yet loaded.
            case (step_at(step_d))
                LD_W:    data_d = latch ? w_in : w_q;
                LD_B:    data_d = latch ? b_in : b_q;
                LD_A:    data_d = latch ? a_in : a_q;
                default: data_d = '0;
            endcase
        end
    end

    assign capture_en = (state_q == RELEASE) && (t_count == CAPT_AT);

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q <= IDLE;
            step_q  <= 4'd0;
            w_q     <= '0;
            b_q     <= '0;
            a_q     <= '0;
            dataIn  <= '0;
            ReadyIn <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            if (latch) begin
                w_q <= w_in;
                b_q <= b_in;
                a_q <= a_in;
            end
            dataIn  <= data_d;
            ReadyIn <= ready_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            re_y <= '0;
            im_y <= '0;
            re_z <= '0;
            im_z <= '0;
        end else if (capture_en) begin
            case (step_at(step_q))
                DISP_REY: re_y <= result;
                DISP_IMY: im_y <= result;
                DISP_REZ: re_z <= result;
                DISP_IMZ: im_z <= result;
                default: ;
            endcase
        end
    end

endmodule
